weight_loader: RTL
==================

Name: weight_loader

Overview:
- Write-side counterpart of the inference core's weight/bias memory read interface.
- Consumes a byte stream from the UART receiver: 2-byte sync header, 7840 signed 8-bit weights, then 10 signed 32-bit biases (little-endian).
- Writes weights into the weight RAM and biases into the bias RAM.
- Drives weights_ready, which gates start_inference in the inference core.

Parameters:
- NUM_CLASSES, 10, number of output classes / bias words.
- NUM_PIXELS, 784, pixels per image; NUM_WEIGHTS = NUM_CLASSES*NUM_PIXELS = 7840.
- SYNC0, 8'hAA, first header byte.
- SYNC1, 8'h55, second header byte.
- TIMEOUT_CYCLES, 1_000_000, max idle clocks between payload bytes before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- weight_we  out  1  weight RAM write enable
- weight_waddr  out  13  weight RAM address, class*784+pixel
- weight_wdata  out  8  weight byte
- bias_we  out  1  bias RAM write enable
- bias_waddr  out  4  bias index 0..9
- bias_wdata  out  32  assembled bias word
- weights_ready  out  1  full image of weights+biases loaded
- load_error  out  1  sticky: last load aborted
- loading  out  1  high in WEIGHTS/BIAS/CHECK

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counters and bias shift register cleared. weights_ready drops immediately, including mid-load.
- Only cycles with rx_valid=1 consume a byte; rx_data is ignored otherwise.
- IDLE: byte==SYNC0 -> SYNC; any other byte is discarded.
- SYNC:
  - byte==SYNC1 -> WEIGHTS; clear weights_ready and load_error; clear counters.
  - byte==SYNC0 -> stay in SYNC.
  - else -> IDLE.
- WEIGHTS: each byte produces weight_we=1 for exactly one cycle, on the cycle after the rx_valid cycle (registered). weight_waddr = byte index 0..7839; weight_wdata = byte. After the write of index 7839 -> BIAS.
- BIAS: bytes are shifted into a 32-bit register LSB-first. On the 4th byte, bias_we=1 for one cycle the following clock, with bias_waddr = bias index and bias_wdata = {b3,b2,b1,b0}. After index 9 -> CHECK if CHECKSUM_EN is defined, else DONE.
- DONE: weights_ready=1 (registered, asserts 1 cycle after the final bias_we). Stays in DONE. A SYNC0 byte -> SYNC path (reload); weights_ready stays 1 until SYNC1 is accepted.
- Timeout: in WEIGHTS/BIAS/CHECK a counter resets on every rx_valid. When it reaches TIMEOUT_CYCLES-1: -> IDLE, load_error=1, weights_ready=0. Partial RAM contents are left as written.
- Header bytes inside the payload (AA 55) are treated as data, not resync.
- No back-pressure: the block accepts one byte per clock, sustained.
- Memory writes never occur outside WEIGHTS/BIAS; weight_we and bias_we are never high in the same cycle.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit modular sum is accumulated over all 7880 payload bytes.
  - State CHECK consumes one extra byte.
  - Byte == sum -> DONE.
  - Mismatch -> IDLE with load_error=1, weights_ready=0.
  - Timeout applies in CHECK.
- Undefined: no CHECK state or accumulator; BIAS goes directly to DONE.

Test Plan:
- Stream AA 55, weights[i]=i[7:0], biases k*256-5 (LE) -> 7840 weight writes with addr==i and data==i[7:0]; bias_wdata[3]==32'h000002FB; weights_ready=1 one cycle after the last bias_we.
- Prefix garbage 12 AA AA 55 then the valid payload -> loads correctly; no write before the first payload byte.
- Stop after 100 weights, idle TIMEOUT_CYCLES clocks -> load_error=1, state IDLE, weights_ready=0; a following valid load clears load_error.
- Assert rst at weight 5000 -> all outputs 0 asynchronously; a fresh full load succeeds.
- Reload while weights_ready=1: send AA -> weights_ready stays 1; send 55 -> weights_ready drops next cycle.
- LOADER_CHECKSUM_EN: correct checksum byte -> weights_ready=1; checksum+1 -> load_error=1, weights_ready=0.

Source files
------------

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - loads the UART weight/bias image into the inference RAMs
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int         NUM_CLASSES    = 10,
  parameter int         NUM_PIXELS     = 784,
  parameter logic [7:0] SYNC0          = 8'hAA,
  parameter logic [7:0] SYNC1          = 8'h55,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        weight_we,
  output logic [12:0] weight_waddr,
  output logic [7:0]  weight_wdata,
  output logic        bias_we,
  output logic [3:0]  bias_waddr,
  output logic [31:0] bias_wdata,
  output logic        weights_ready,
  output logic        load_error,
  output logic        loading
);

  localparam int NUM_WEIGHTS = NUM_CLASSES * NUM_PIXELS;
  localparam int TW          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_WEIGHTS,
    S_BIAS,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   widx_q, widx_d;
  logic [3:0]    bidx_q, bidx_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          weight_we_q, weight_we_d;
  logic [12:0]   weight_waddr_q, weight_waddr_d;
  logic [7:0]    weight_wdata_q, weight_wdata_d;
  logic          bias_we_q, bias_we_d;
  logic [3:0]    bias_waddr_q, bias_waddr_d;
  logic [31:0]   bias_wdata_q, bias_wdata_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;
  logic          in_payload;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  always_comb begin
    in_payload = (state_q == S_WEIGHTS) || (state_q == S_BIAS);
`ifdef LOADER_CHECKSUM_EN
    in_payload = in_payload || (state_q == S_CHECK);
`endif
  end

  always_comb begin
    state_d        = state_q;
    widx_d         = widx_q;
    bidx_d         = bidx_q;
    bcnt_d         = bcnt_q;
    shift_d        = shift_q;
    tmo_d          = tmo_q;
    weight_we_d    = 1'b0;
    weight_waddr_d = weight_waddr_q;
    weight_wdata_d = weight_wdata_q;
    bias_we_d      = 1'b0;
    bias_waddr_d   = bias_waddr_q;
    bias_wdata_d   = bias_wdata_q;
    ready_d        = ready_q;
    error_d        = error_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d          = sum_q;
    if (rx_valid && ((state_q == S_WEIGHTS) || (state_q == S_BIAS))) begin
      sum_d = sum_q + rx_data;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC0) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (rx_valid) begin
          if (rx_data == SYNC1) begin
            state_d = S_WEIGHTS;
            ready_d = 1'b0;
            error_d = 1'b0;
            widx_d  = '0;
            bidx_d  = '0;
            bcnt_d  = '0;
            shift_d = '0;
            tmo_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else if (rx_data != SYNC0) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WEIGHTS: begin
        if (rx_valid) begin
          weight_we_d    = 1'b1;
          weight_waddr_d = widx_q;
          weight_wdata_d = rx_data;
          widx_d         = widx_q + 13'd1;
          if (widx_q == 13'(NUM_WEIGHTS - 1)) state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        if (rx_valid) begin
          // Little-endian: earlier bytes migrate toward the low end of the word.
          if (bcnt_q == 2'd3) begin
            bias_we_d    = 1'b1;
            bias_waddr_d = bidx_q;
            bias_wdata_d = {rx_data, shift_q};
            shift_d      = '0;
            bcnt_d       = '0;
            bidx_d       = bidx_q + 4'd1;
            if (bidx_q == 4'(NUM_CLASSES - 1)) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end
          end else begin
            shift_d = {rx_data, shift_q[23:8]};
            bcnt_d  = bcnt_q + 2'd1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
            error_d = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
`endif
      S_DONE: begin
        // Ready holds through a reload header until SYNC1 commits the new load.
        ready_d = 1'b1;
        if (rx_valid && rx_data == SYNC0) state_d = S_SYNC;
      end
      default: state_d = S_IDLE;
    endcase

    if (in_payload) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        error_d = 1'b1;
        ready_d = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      widx_q         <= '0;
      bidx_q         <= '0;
      bcnt_q         <= '0;
      shift_q        <= '0;
      tmo_q          <= '0;
      weight_we_q    <= 1'b0;
      weight_waddr_q <= '0;
      weight_wdata_q <= '0;
      bias_we_q      <= 1'b0;
      bias_waddr_q   <= '0;
      bias_wdata_q   <= '0;
      ready_q        <= 1'b0;
      error_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      widx_q         <= widx_d;
      bidx_q         <= bidx_d;
      bcnt_q         <= bcnt_d;
      shift_q        <= shift_d;
      tmo_q          <= tmo_d;
      weight_we_q    <= weight_we_d;
      weight_waddr_q <= weight_waddr_d;
      weight_wdata_q <= weight_wdata_d;
      bias_we_q      <= bias_we_d;
      bias_waddr_q   <= bias_waddr_d;
      bias_wdata_q   <= bias_wdata_d;
      ready_q        <= ready_d;
      error_q        <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign weight_we     = weight_we_q;
  assign weight_waddr  = weight_waddr_q;
  assign weight_wdata  = weight_wdata_q;
  assign bias_we       = bias_we_q;
  assign bias_waddr    = bias_waddr_q;
  assign bias_wdata    = bias_wdata_q;
  assign weights_ready = ready_q;
  assign load_error    = error_q;
  assign loading       = in_payload;

endmodule
